uart_cmd_responder: RTL and testbench
=====================================

Name: uart_cmd_responder

Overview:
- System-side responder for the host link: pops 32-bit command words that arrive from the host via the writeout buffer, executes them against a word-addressed memory port, and pushes reply words into the readin buffer for transmission back to the host.
- Decodes host-initiated PING, WRITE and READ packets.
- Provides the protocol endpoint that gives the raw JTAG UART word stream its meaning.

Parameters:
- TIMEOUT, 1024, cycles to wait for mem_ack_i before aborting a memory access (counter width = $clog2(TIMEOUT)+1).
- PING_ID, 32'h5A5A0001, reply word for the PING opcode.

Ports:
- clock_i  input  1  system clock.
- resetn_i  input  1  asynchronous active-low reset.
- rx_empty_i  input  1  writeout buffer empty; rx_data_i is valid when low (show-ahead FIFO).
- rx_data_i  input  32  head word of the writeout buffer.
- rx_read_o  output  1  one-cycle pop of the writeout buffer.
- tx_full_i  input  1  readin buffer full.
- tx_write_o  output  1  one-cycle push into the readin buffer.
- tx_data_o  output  32  word pushed; valid when tx_write_o is high.
- mem_req_o  output  1  memory request, level, held until ack.
- mem_wren_o  output  1  1 = write, 0 = read; stable while mem_req_o is high.
- mem_addr_o  output  32  byte address; stable while mem_req_o is high.
- mem_wdata_o  output  32  write data; stable while mem_req_o is high.
- mem_ack_i  input  1  single-cycle completion; mem_rdata_i is valid in the same cycle.
- mem_rdata_i  input  32  read data.

Behaviour:
- Reset:
  - Asynchronous assertion forces state IDLE.
  - All outputs are 0 and all counters are 0, including mid-packet; there is no resume.
  - Memory side: mem_req_o drops immediately. The memory slave must tolerate an abandoned request.
- Packet format:
  - Header word: [31:24] opcode, [23:0] LEN (word count).
  - Header is followed by an address word for WRITE/READ, then LEN data words for WRITE.
- Opcodes:
  - 8'h01 WRITE.
  - 8'h02 READ.
  - 8'h03 PING (no address word).
- Status word:
  - {8'hA5, count} on success, {8'hEE, count} on timeout.
  - count = words completed.
  - An unknown opcode replies {8'hEE, 16'h0000, opcode}.
- rx_read_o:
  - Asserted only when rx_empty_i is low.
  - Each pop consumes exactly one word; the word is captured in the same cycle as the pop.
- tx_write_o:
  - Asserted only when tx_full_i is low.
  - Otherwise the block holds in its current state with tx_data_o stable.
- States:
  - IDLE: on !rx_empty_i, pop the header and latch opcode/LEN. WRITE/READ -> ADDR, PING -> REPLY(PING_ID), other -> REPLY(error).
  - ADDR: on !rx_empty_i, pop and latch the address; clear count. WRITE -> WDATA, READ -> RREQ. If LEN = 0, go straight to STATUS with {A5, 0}.
  - WDATA: pop a data word, latch it into mem_wdata_o -> WREQ.
  - WREQ: mem_req_o=1, mem_wren_o=1.
    - On mem_ack_i: deassert the next cycle, address += 4, count += 1.
    - If count == LEN -> STATUS, else -> WDATA.
  - RREQ: mem_req_o=1, mem_wren_o=0.
    - On mem_ack_i: latch mem_rdata_i -> RPUSH.
  - RPUSH: push the latched word, address += 4, count += 1. If count == LEN -> STATUS, else -> RREQ.
  - DRAIN: pop the remaining LEN - count - 1 write data words without issuing memory requests, then -> STATUS. Keeps the host stream aligned after a timed-out WRITE.
  - REPLY / STATUS: push one word -> IDLE.
- Timeout:
  - The timer counts while mem_req_o is high and resets on every new request.
  - At TIMEOUT cycles without ack: drop mem_req_o and latch the error flag.
  - A timed-out WRITE -> DRAIN (or STATUS if no words remain). A timed-out READ -> STATUS immediately.
  - The failed word is not counted.
- A mem_ack_i arriving in the same cycle the timeout expires counts as success.
- The address wraps modulo 2^32.
- count and LEN are 24-bit; the maximum LEN is 24'hFFFFFF.
- Latency:
  - Header pop to PING reply push is 1 cycle minimum (IDLE -> REPLY).
  - mem_ack_i -> next mem_req_o on WRITE is 2 cycles minimum (ack, WDATA pop).

Test Plan:
- PING: push 32'h03000000 with tx not full -> exactly one rx pop and one push of 32'h5A5A0001; state back to IDLE; no mem_req_o.
- WRITE: push 32'h01000003, 32'h00001000, then data 11, 22, 33, with 1-cycle acks -> writes to 0x1000, 0x1004, 0x1008 with the matching data, then status 32'hA5000003.
- READ with stalls: push 32'h02000002, 32'h00002000; rdata = DEAD0001, DEAD0002; tx_full_i held high 5 cycles on the first push -> tx_data_o stable across the stall, pushes DEAD0001, DEAD0002, A5000002 in order.
- Timeout: WRITE LEN=3 with mem_ack_i never asserted, TIMEOUT=16 -> mem_req_o drops after 16 cycles, two trailing words drained, status 32'hEE000000, next PING answered correctly.
- Unknown opcode plus empty gaps: push 32'h7F000000 with rx_empty_i toggling -> single reply 32'hEE00007F; no pop while empty.
- Reset mid-READ: assert resetn_i low while mem_req_o is high -> all outputs 0 asynchronously; after release a PING is answered normally.

Source files
------------

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder
// Host-link command endpoint. Pops 32-bit command words from the writeout
// FIFO (show-ahead), executes PING / WRITE / READ packets against a
// word-addressed memory port and pushes reply words into the readin FIFO.
//
// Packet: header {opcode[31:24], LEN[23:0]}, then an address word for
// WRITE/READ, then LEN data words for WRITE. Every packet ends with exactly
// one reply word (PING id, status, or unknown-opcode error); READ also
// pushes its LEN data words ahead of the status word.
module uart_cmd_responder #(
  parameter int unsigned TIMEOUT = 1024,
  parameter logic [31:0] PING_ID = 32'h5A5A0001
) (
  input  logic        clock_i,
  input  logic        resetn_i,
  // writeout buffer (host -> system)
  input  logic        rx_empty_i,
  input  logic [31:0] rx_data_i,
  output logic        rx_read_o,
  // readin buffer (system -> host)
  input  logic        tx_full_i,
  output logic        tx_write_o,
  output logic [31:0] tx_data_o,
  // memory port
  output logic        mem_req_o,
  output logic        mem_wren_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_PING  = 8'h03;
  localparam logic [7:0] ST_OK    = 8'hA5;
  localparam logic [7:0] ST_ERR   = 8'hEE;

  typedef struct packed {
    logic [7:0]  op;
    logic [23:0] len;
  } hdr_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WREQ,
    S_RREQ,
    S_RPUSH,
    S_DRAIN,
    S_REPLY,
    S_STATUS
  } state_e;

  state_e          state_q;
  logic            go_q;      // low for the first cycle after reset release
  logic [7:0]      op_q;
  logic [23:0]     len_q;
  logic [23:0]     cnt_q;     // words completed in the current packet
  logic [23:0]     drain_q;   // write data words still to discard
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     txd_q;     // word offered to the readin FIFO
  logic [TW-1:0]   tmr_q;
  logic            err_q;
  logic            req_q;
  logic            wren_q;

  hdr_t            hdr;
  logic            pop_state;
  logic            push_state;
  logic [23:0]     cnt_inc;
  logic [23:0]     remain;
  logic            tmo;

  assign hdr     = hdr_t'(rx_data_i);
  assign cnt_inc = cnt_q + 24'd1;
  // write data words left in the stream after the one that just failed
  assign remain  = len_q - cnt_q - 24'd1;
  assign tmo     = (tmr_q == TW'(TIMEOUT - 1));

  // States that consume a host word / produce a reply word. The handshake
  // itself is gated by the FIFO flags so a pop or push is always legal.
  assign pop_state  = go_q && (state_q == S_IDLE  || state_q == S_ADDR ||
                               state_q == S_WDATA || state_q == S_DRAIN);
  assign push_state = (state_q == S_RPUSH || state_q == S_REPLY ||
                       state_q == S_STATUS);

  assign rx_read_o   = pop_state && !rx_empty_i;
  assign tx_write_o  = push_state && !tx_full_i;
  assign tx_data_o   = txd_q;
  assign mem_req_o   = req_q;
  assign mem_wren_o  = wren_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  // Packet sequencer: decode, memory handshake with timeout, reply generation.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= S_IDLE;
      go_q    <= 1'b0;
      op_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      txd_q   <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      wren_q  <= 1'b0;
    end else begin
      go_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (rx_read_o) begin
            op_q  <= hdr.op;
            len_q <= hdr.len;
            err_q <= 1'b0;
            case (hdr.op)
              OP_WRITE, OP_READ: state_q <= S_ADDR;
              OP_PING: begin
                txd_q   <= PING_ID;
                state_q <= S_REPLY;
              end
              default: begin
                txd_q   <= {ST_ERR, 16'h0000, hdr.op};
                state_q <= S_REPLY;
              end
            endcase
          end
        end

        S_ADDR: begin
          if (rx_read_o) begin
            addr_q <= rx_data_i;
            cnt_q  <= '0;
            if (len_q == 24'd0) begin
              txd_q   <= {ST_OK, 24'd0};
              state_q <= S_STATUS;
            end else if (op_q == OP_WRITE) begin
              state_q <= S_WDATA;
            end else begin
              req_q   <= 1'b1;
              wren_q  <= 1'b0;
              tmr_q   <= '0;
              state_q <= S_RREQ;
            end
          end
        end

        S_WDATA: begin
          if (rx_read_o) begin
            wdata_q <= rx_data_i;
            req_q   <= 1'b1;
            wren_q  <= 1'b1;
            tmr_q   <= '0;
            state_q <= S_WREQ;
          end
        end

        // An ack in the expiry cycle wins over the timeout.
        S_WREQ: begin
          if (mem_ack_i) begin
            req_q  <= 1'b0;
            wren_q <= 1'b0;
            addr_q <= addr_q + 32'd4;
            cnt_q  <= cnt_inc;
            if (cnt_inc == len_q) begin
              txd_q   <= {ST_OK, cnt_inc};
              state_q <= S_STATUS;
            end else begin
              state_q <= S_WDATA;
            end
          end else if (tmo) begin
            req_q  <= 1'b0;
            wren_q <= 1'b0;
            err_q  <= 1'b1;
            if (remain == 24'd0) begin
              txd_q   <= {ST_ERR, cnt_q};
              state_q <= S_STATUS;
            end else begin
              drain_q <= remain;
              state_q <= S_DRAIN;
            end
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end

        S_RREQ: begin
          if (mem_ack_i) begin
            req_q   <= 1'b0;
            txd_q   <= mem_rdata_i;
            state_q <= S_RPUSH;
          end else if (tmo) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            txd_q   <= {ST_ERR, cnt_q};
            state_q <= S_STATUS;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end

        S_RPUSH: begin
          if (tx_write_o) begin
            addr_q <= addr_q + 32'd4;
            cnt_q  <= cnt_inc;
            if (cnt_inc == len_q) begin
              txd_q   <= {ST_OK, cnt_inc};
              state_q <= S_STATUS;
            end else begin
              req_q   <= 1'b1;
              wren_q  <= 1'b0;
              tmr_q   <= '0;
              state_q <= S_RREQ;
            end
          end
        end

        // Swallow the rest of a failed WRITE so the next header lines up.
        S_DRAIN: begin
          if (rx_read_o) begin
            drain_q <= drain_q - 24'd1;
            if (drain_q == 24'd1) begin
              txd_q   <= {(err_q ? ST_ERR : ST_OK), cnt_q};
              state_q <= S_STATUS;
            end
          end
        end

        S_REPLY, S_STATUS: begin
          if (tx_write_o) state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder: packets are queued as host words,
// a reference model predicts replies and memory accesses, and independent
// monitors compare what the DUT actually does.
module tb_uart_cmd_responder;

  localparam int          TMO  = 16;
  localparam logic [31:0] PID  = 32'h5A5A0001;

  logic        clk;
  logic        rstn;
  logic        rx_empty_i, rx_read_o, tx_full_i, tx_write_o;
  logic [31:0] rx_data_i, tx_data_o;
  logic        mem_req_o, mem_wren_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  uart_cmd_responder #(.TIMEOUT(TMO), .PING_ID(PID)) dut (
    .clock_i     (clk),
    .resetn_i    (rstn),
    .rx_empty_i  (rx_empty_i),
    .rx_data_i   (rx_data_i),
    .rx_read_o   (rx_read_o),
    .tx_full_i   (tx_full_i),
    .tx_write_o  (tx_write_o),
    .tx_data_o   (tx_data_o),
    .mem_req_o   (mem_req_o),
    .mem_wren_o  (mem_wren_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } mop_t;

  logic [31:0] rx_q[$];      // host words not yet popped
  logic [31:0] exp_tx[$];    // expected reply words
  mop_t        exp_mem[$];   // expected memory requests
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] sim_mem[logic [31:0]];

  int n_cmp = 0;
  int n_bad = 0;
  int ack_mode = 0;          // 0 random delay, 1 never ack, 2 fixed delay
  int fix_dly = 0;
  int gap_pct = 0;
  int full_pct = 0;
  bit force_full = 1'b0;

  // memory slave bookkeeping (driver process only)
  bit          in_req;
  bit          stable;
  int          req_len;
  int          dly;
  logic        req_wr;
  logic [31:0] req_addr, req_wd;

  function automatic logic [31:0] fill(input logic [31:0] a);
    return a ^ 32'hC0DE0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic end_req(input bit acked);
    mop_t e;
    if (exp_mem.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL unexpected_mem_req: addr %h wr %0d at %0t", req_addr, req_wr, $time);
    end else begin
      e = exp_mem.pop_front();
      chk("mem_wren", {31'd0, req_wr}, {31'd0, e.wr});
      chk("mem_addr", req_addr, e.addr);
      if (e.wr) chk("mem_wdata", req_wd, e.data);
      chk("mem_req_stable", {31'd0, stable}, 32'd1);
      if (!acked) chk("timeout_len", req_len, TMO);
    end
  endtask

  // Host FIFO + memory slave: drive at negedge, observe handshakes 1ns later.
  initial begin
    rx_empty_i = 1'b1; rx_data_i = '0; tx_full_i = 1'b0;
    mem_ack_i = 1'b0; mem_rdata_i = '0; in_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_q.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
        rx_empty_i = 1'b0; rx_data_i = rx_q[0];
      end else begin
        rx_empty_i = 1'b1; rx_data_i = $urandom;
      end
      tx_full_i = force_full || (int'($urandom_range(99)) < full_pct);
      mem_ack_i = 1'b0;
      mem_rdata_i = $urandom;
      if (!rstn) begin
        in_req = 1'b0;
      end else if (mem_req_o) begin
        if (!in_req) begin
          in_req = 1'b1; stable = 1'b1; req_len = 0;
          req_addr = mem_addr_o; req_wr = mem_wren_o; req_wd = mem_wdata_o;
          dly = (ack_mode == 0) ? int'($urandom_range(0, 5)) : fix_dly;
        end else if (mem_addr_o !== req_addr || mem_wren_o !== req_wr ||
                     (req_wr && mem_wdata_o !== req_wd)) begin
          stable = 1'b0;
        end
        if (ack_mode != 1 && req_len == dly) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = sim_mem.exists(mem_addr_o) ? sim_mem[mem_addr_o] : fill(mem_addr_o);
        end
        req_len++;
      end else if (in_req) begin
        in_req = 1'b0;
        end_req(1'b0);
      end
      #1;
      if (rx_read_o) begin
        chk("pop_when_nonempty", {31'd0, rx_empty_i}, 32'd0);
        if (!rx_empty_i && rx_q.size() > 0) void'(rx_q.pop_front());
      end
      if (mem_ack_i) begin
        if (req_wr) sim_mem[req_addr] = req_wd;
        in_req = 1'b0;
        end_req(1'b1);
      end
    end
  end

  // Reply monitor: every push is checked against the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rstn && tx_write_o) begin
        chk("push_when_not_full", {31'd0, tx_full_i}, 32'd0);
        if (exp_tx.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_push: got %h at %0t", tx_data_o, $time);
        end else begin
          chk("tx_data", tx_data_o, exp_tx.pop_front());
        end
      end
    end
  end

  // ---------------- reference model (packet level) ----------------
  task automatic ping();
    rx_q.push_back(32'h03000000);
    exp_tx.push_back(PID);
  endtask

  task automatic bad_op(input logic [7:0] op, input logic [23:0] len);
    rx_q.push_back({op, len});
    exp_tx.push_back({8'hEE, 16'h0000, op});
  endtask

  task automatic wr_pkt(input logic [31:0] a, input logic [31:0] d[$], input bit ok);
    mop_t m;
    int n = d.size();
    rx_q.push_back({8'h01, 24'(n)});
    rx_q.push_back(a);
    foreach (d[i]) rx_q.push_back(d[i]);
    if (n == 0) begin
      exp_tx.push_back(32'hA5000000);
    end else if (ok) begin
      foreach (d[i]) begin
        m.wr = 1'b1; m.addr = a + 32'(4 * i); m.data = d[i];
        exp_mem.push_back(m);
        ref_mem[m.addr] = d[i];
      end
      exp_tx.push_back({8'hA5, 24'(n)});
    end else begin
      m.wr = 1'b1; m.addr = a; m.data = d[0];
      exp_mem.push_back(m);
      exp_tx.push_back(32'hEE000000);
    end
  endtask

  task automatic rd_pkt(input logic [31:0] a, input int n, input bit ok);
    mop_t m;
    logic [31:0] ad;
    rx_q.push_back({8'h02, 24'(n)});
    rx_q.push_back(a);
    if (n == 0) begin
      exp_tx.push_back(32'hA5000000);
    end else if (ok) begin
      for (int i = 0; i < n; i++) begin
        ad = a + 32'(4 * i);
        m.wr = 1'b0; m.addr = ad; m.data = '0;
        exp_mem.push_back(m);
        exp_tx.push_back(ref_mem.exists(ad) ? ref_mem[ad] : fill(ad));
      end
      exp_tx.push_back({8'hA5, 24'(n)});
    end else begin
      m.wr = 1'b0; m.addr = a; m.data = '0;
      exp_mem.push_back(m);
      exp_tx.push_back(32'hEE000000);
    end
  endtask

  task automatic wait_done(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (rx_q.size() == 0 && exp_tx.size() == 0 && exp_mem.size() == 0 && !mem_req_o)
        done = 1'b1;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL drain_budget: rx %0d tx %0d mem %0d left after %0d cycles",
               rx_q.size(), exp_tx.size(), exp_mem.size(), budget);
      rx_q.delete(); exp_tx.delete(); exp_mem.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rx_read"},  {31'd0, rx_read_o},  32'd0);
    chk({tag, "_tx_write"}, {31'd0, tx_write_o}, 32'd0);
    chk({tag, "_tx_data"},  tx_data_o,           32'd0);
    chk({tag, "_mem_req"},  {31'd0, mem_req_o},  32'd0);
    chk({tag, "_mem_wren"}, {31'd0, mem_wren_o}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr_o,          32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata_o,        32'd0);
  endtask

  logic [31:0] dq[$];
  logic [31:0] ra;
  int          k, n;
  bit          seen;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    // a header waits in the FIFO during reset: nothing may be popped
    ping();
    repeat (2) @(negedge clk);
    #3 chk_outputs_zero("reset");
    @(negedge clk);
    rstn = 1'b1;
    wait_done(100);

    // directed WRITE, single-cycle acks
    ack_mode = 2; fix_dly = 0;
    dq = '{32'h11, 32'h22, 32'h33};
    wr_pkt(32'h00001000, dq, 1'b1);
    wait_done(200);

    // READ with a 5-cycle readin stall on the first data word
    sim_mem[32'h2000] = 32'hDEAD0001; ref_mem[32'h2000] = 32'hDEAD0001;
    sim_mem[32'h2004] = 32'hDEAD0002; ref_mem[32'h2004] = 32'hDEAD0002;
    force_full = 1'b1;
    rd_pkt(32'h00002000, 2, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk); #1;
      if (mem_ack_i) seen = 1'b1;
    end
    chk("stall_ack_seen", {31'd0, seen}, 32'd1);
    repeat (5) begin
      @(negedge clk); #3;
      chk("stall_tx_data", tx_data_o, 32'hDEAD0001);
      chk("stall_no_req", {31'd0, mem_req_o}, 32'd0);
    end
    force_full = 1'b0;
    wait_done(300);

    // timeouts: WRITE drained, short WRITE, READ; PING afterwards stays aligned
    ack_mode = 1;
    dq = '{32'hA1, 32'hA2, 32'hA3};
    wr_pkt(32'h00000300, dq, 1'b0);
    ping();
    dq = '{32'hB1};
    wr_pkt(32'h00000310, dq, 1'b0);
    rd_pkt(32'h00000320, 2, 1'b0);
    ping();
    wait_done(400);

    // ack in the very cycle the timer expires still counts as success
    ack_mode = 2; fix_dly = TMO - 1;
    dq = '{32'hC1, 32'hC2};
    wr_pkt(32'h00000330, dq, 1'b1);
    rd_pkt(32'h00000330, 2, 1'b1);
    wait_done(400);

    // unknown opcodes with a bursty, gappy host stream
    ack_mode = 0; gap_pct = 60;
    bad_op(8'h7F, 24'h000000);
    bad_op(8'h00, 24'h123456);
    bad_op(8'hFF, 24'hFFFFFF);
    ping();
    wait_done(400);

    // address wrap modulo 2^32
    gap_pct = 20; full_pct = 20;
    dq = '{32'hE0, 32'hE1, 32'hE2, 32'hE3};
    wr_pkt(32'hFFFFFFF8, dq, 1'b1);
    rd_pkt(32'hFFFFFFF8, 4, 1'b1);
    wait_done(600);

    // randomized mix
    gap_pct = 25; full_pct = 25;
    for (int p = 0; p < 150; p++) begin
      k  = int'($urandom_range(0, 9));
      n  = int'($urandom_range(0, 6));
      ra = 32'($urandom_range(0, 31)) * 32'd4;
      if (k < 4) begin
        dq.delete();
        repeat (n) dq.push_back($urandom);
        wr_pkt(ra, dq, 1'b1);
      end else if (k < 8) begin
        rd_pkt(ra, n, 1'b1);
      end else if (k == 8) begin
        ping();
      end else begin
        bad_op(8'($urandom_range(4, 255)), 24'($urandom));
      end
    end
    wait_done(30000);

    // reset in the middle of a READ with the request outstanding
    ack_mode = 1; gap_pct = 0; full_pct = 0;
    rd_pkt(32'h00000040, 3, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (mem_req_o) seen = 1'b1;
    end
    chk("midread_req_seen", {31'd0, seen}, 32'd1);
    #3 rstn = 1'b0;
    #1 chk_outputs_zero("async_reset");
    rx_q.delete(); exp_tx.delete(); exp_mem.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    ack_mode = 0;
    ping();
    wait_done(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
